// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage sequencer: owns fetch PC, credit-limited I-cache issue, decode queue
// Stale I-cache responses after a redirect are counted in r_discard and dropped on arrival.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef DataWidth
`define DataWidth 32
`endif

module fetch_ctrl #(
  parameter int              ADDR      = `AddrWidth,
  parameter int              DATA      = `DataWidth,
  parameter logic [ADDR-1:0] RESET_VEC = '0,
  parameter int              DEPTH     = 2
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            redirect_e_,
  input  logic [ADDR-1:0] redirect_pc,
  output logic            fetch_e_,
  output logic [ADDR-1:0] fetch_pc,
  input  logic            ic_busy,
  input  logic            ic_e_,
  input  logic [DATA-1:0] ic_inst,
  output logic            inst_e_,
  output logic [ADDR-1:0] inst_pc,
  output logic [DATA-1:0] inst,
  input  logic            dec_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   L_DEPTH = (CW+1)'(DEPTH);
  localparam logic [ADDR-1:0] L_STEP = ADDR'(4);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ADDR-1:0] r_fetch_pc;
  logic [ADDR-1:0] r_resp_pc;
  logic [CW-1:0]   r_in_flight;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   r_q_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [ADDR-1:0] r_q_pc   [DEPTH];
  logic [DATA-1:0] r_q_inst [DEPTH];

  logic            w_redirect;
  logic            w_resp;
  logic [CW:0]     w_credit_used;
  logic            w_issue;
  logic            w_accept;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_in_flight_nxt;
  logic [CW-1:0]   w_discard_nxt;

  assign w_redirect    = ~redirect_e_;
  assign w_resp        = ~ic_e_;
  assign w_credit_used = {1'b0, r_in_flight} + {1'b0, r_q_count};

  // Every response arriving during a redirect or while discards are pending is stale.
  assign w_drop   = w_resp & (w_redirect | (r_discard != '0));
  assign w_push   = w_resp & ~w_drop;
  assign w_accept = w_issue & ~ic_busy;
  assign w_pop    = ~inst_e_ & ~dec_stall;

  always_comb begin
    w_in_flight_nxt = r_in_flight;
    if (w_accept && !w_resp) begin
      w_in_flight_nxt = r_in_flight + CW'(1);
    end else if (!w_accept && w_resp) begin
      w_in_flight_nxt = r_in_flight - CW'(1);
    end
  end

  // A redirect never issues, so everything still outstanding afterwards is stale.
  always_comb begin
    w_discard_nxt = r_discard;
    if (w_redirect) begin
      w_discard_nxt = w_in_flight_nxt;
    end else if (w_resp && (r_discard != '0)) begin
      w_discard_nxt = r_discard - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        w_issue = ~w_redirect & (w_credit_used < L_DEPTH);
        if (w_redirect && (w_in_flight_nxt != '0)) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        w_issue = ~w_redirect & (w_credit_used < L_DEPTH);
        if (!w_redirect && (w_discard_nxt == '0)) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
    fetch_e_ = ~w_issue;
    inst_e_  = ~((r_q_count != '0) & ~w_redirect);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_fetch_pc  <= RESET_VEC;
      r_resp_pc   <= RESET_VEC;
      r_in_flight <= '0;
      r_discard   <= '0;
    end else begin
      r_in_flight <= w_in_flight_nxt;
      r_discard   <= w_discard_nxt;
      if (w_redirect) begin
        r_fetch_pc <= redirect_pc;
        r_resp_pc  <= redirect_pc;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + L_STEP;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + L_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_q_count <= '0;
    end else if (w_redirect) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_q_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_q_count <= r_q_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_q_count <= r_q_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]   <= '0;
        r_q_inst[i] <= '0;
      end
    end else if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_resp_pc;
      r_q_inst[r_wr_ptr] <= ic_inst;
    end
  end

  assign fetch_pc = r_fetch_pc;
  assign inst_pc  = r_q_pc[r_rd_ptr];
  assign inst     = r_q_inst[r_rd_ptr];

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
// Model tracks outstanding requests (with stale marks) and the decode queue as plain queues.
module tb_fetch_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        redirect_e_ = 1'b1;
  logic [31:0] redirect_pc = '0;
  logic        ic_busy = 1'b0;
  logic        ic_e_ = 1'b1;
  logic [31:0] ic_inst = '0;
  logic        dec_stall = 1'b0;
  logic        fetch_e_;
  logic [31:0] fetch_pc;
  logic        inst_e_;
  logic [31:0] inst_pc;
  logic [31:0] inst;

  int n_checks = 0;
  int n_fail = 0;

  bit          m_boot = 1'b1;
  logic [31:0] m_fetch_pc = '0;
  logic [31:0] os_pc[$];
  bit          os_stale[$];
  logic [31:0] iq_pc[$];
  logic [31:0] iq_inst[$];

  fetch_ctrl #(.ADDR(32), .DATA(32), .RESET_VEC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_(reset_), .redirect_e_(redirect_e_), .redirect_pc(redirect_pc),
    .fetch_e_(fetch_e_), .fetch_pc(fetch_pc), .ic_busy(ic_busy), .ic_e_(ic_e_),
    .ic_inst(ic_inst), .inst_e_(inst_e_), .inst_pc(inst_pc), .inst(inst),
    .dec_stall(dec_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] icdata(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function bit exp_issue();
    return !m_boot && redirect_e_ && ((os_pc.size() + iq_pc.size()) < DEPTH);
  endfunction

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      m_boot = 1'b1;
      m_fetch_pc = '0;
      os_pc.delete();
      os_stale.delete();
      iq_pc.delete();
      iq_inst.delete();
    end else begin
      bit          acc;
      bit          stale;
      logic [31:0] rpc;
      acc = exp_issue() && !ic_busy;
      if (iq_pc.size() > 0 && redirect_e_ && !dec_stall) begin
        void'(iq_pc.pop_front());
        void'(iq_inst.pop_front());
      end
      if (!ic_e_) begin
        chk("resp_in_flight", 32'(os_pc.size() > 0), 32'd1);
        if (os_pc.size() > 0) begin
          rpc = os_pc.pop_front();
          stale = os_stale.pop_front();
          if (!stale && redirect_e_) begin
            chk("q_no_overflow", 32'(iq_pc.size() < DEPTH), 32'd1);
            iq_pc.push_back(rpc);
            iq_inst.push_back(ic_inst);
          end
        end
      end
      if (!redirect_e_) begin
        iq_pc.delete();
        iq_inst.delete();
        foreach (os_stale[i]) os_stale[i] = 1'b1;
        m_fetch_pc = redirect_pc;
      end else if (acc) begin
        os_pc.push_back(m_fetch_pc);
        os_stale.push_back(1'b0);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      m_boot = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("fetch_e_", 32'(fetch_e_), 32'(!exp_issue()));
    chk("fetch_pc", fetch_pc, m_fetch_pc);
    chk("inst_e_", 32'(inst_e_), 32'(!(iq_pc.size() > 0 && redirect_e_)));
    if (iq_pc.size() > 0 && redirect_e_) begin
      chk("inst_pc", inst_pc, iq_pc[0]);
      chk("inst", inst, iq_inst[0]);
    end
  end

  task automatic step(input bit busy, input bit stall, input bit redir,
                      input logic [31:0] rpc, input bit ren);
    @(posedge clk);
    #1;
    ic_busy = busy;
    dec_stall = stall;
    redirect_e_ = !redir;
    redirect_pc = rpc;
    if (ren && os_pc.size() > 0) begin
      ic_e_ = 1'b0;
      ic_inst = icdata(os_pc[0]);
    end else begin
      ic_e_ = 1'b1;
      ic_inst = '0;
    end
    #1;
  endtask

  task automatic dstep();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_fetch_e_"}, 32'(fetch_e_), 32'd1);
    chk({tag, "_fetch_pc"}, fetch_pc, 32'h0);
    chk({tag, "_inst_e_"}, 32'(inst_e_), 32'd1);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_ = 1'b1;
    #1;
    chk_reset_vals("boot");
    dstep();
    chk("c1_fetch_e_", 32'(fetch_e_), 32'd0);
    chk("c1_fetch_pc", fetch_pc, 32'h0);
    dstep();
    dstep();
    chk("c3_inst_e_", 32'(inst_e_), 32'd0);
    chk("c3_inst_pc", inst_pc, 32'h0);
    chk("c3_inst", inst, 32'hA5A5_0000);

    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("busy_fetch_e_", 32'(fetch_e_), 32'd0);
    chk("busy_fetch_pc", fetch_pc, 32'h8);
    repeat (3) dstep();
    chk("busy_inst_pc", inst_pc, 32'h8);

    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_fetch_e_", 32'(fetch_e_), 32'd1);
    chk("stall_inst_e_", 32'(inst_e_), 32'd0);
    chk("stall_inst_pc", inst_pc, 32'hC);
    repeat (2) dstep();
    chk("rel_inst_pc", inst_pc, 32'h10);
    chk("rel_fetch_pc", fetch_pc, 32'h14);
    chk("rel_fetch_e_", 32'(fetch_e_), 32'd0);

    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    dstep();
    chk("rd1_fetch_pc", fetch_pc, 32'h100);
    chk("rd1_fetch_e_", 32'(fetch_e_), 32'd1);
    chk("rd1_inst_e_", 32'(inst_e_), 32'd1);
    repeat (3) dstep();
    chk("rd1_inst_pc", inst_pc, 32'h100);
    chk("rd1_inst", inst, 32'hA5A5_0100);

    dstep();
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
    chk("rd2_resp_present", 32'(ic_e_), 32'd0);
    dstep();
    chk("rd2_fetch_pc", fetch_pc, 32'h200);
    chk("rd2_fetch_e_", 32'(fetch_e_), 32'd0);
    chk("rd2_inst_e_", 32'(inst_e_), 32'd1);
    repeat (2) dstep();
    chk("rd2_inst_pc", inst_pc, 32'h200);

    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (3) dstep();
    chk("wrap_fetch_pc", fetch_pc, 32'h0);
    chk("wrap_fetch_e_", 32'(fetch_e_), 32'd1);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFF8);

    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("flush_fetch_pc", fetch_pc, 32'h300);
    reset_ = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    reset_ = 1'b1;
    #1;
    chk("boot2_fetch_e_", 32'(fetch_e_), 32'd1);

    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h500, 1'b1);
    dstep();
    chk("rd3_fetch_pc", fetch_pc, 32'h500);
    chk("rd3_fetch_e_", 32'(fetch_e_), 32'd0);
    repeat (2) dstep();
    chk("rd3_inst_pc", inst_pc, 32'h500);
    repeat (10) dstep();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
